// File: rtl/fpu_writeback_arbiter_pkg.sv
// Shared float writeback definitions: default widths, FIFO depth and the writeback record.
// fpu_controller and the integer writeback import the same package.
package fpu_writeback_arbiter_pkg;

  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;
  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic             en;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_t;

endpackage

// File: rtl/fpu_writeback_arbiter_if.sv
// Float writeback bus: FPU result stream, load handshake, regfile write port and decode query.
interface fpu_writeback_arbiter_if
  import fpu_writeback_arbiter_pkg::*;
#(
  parameter int AW = WB_AW,
  parameter int DW = WB_DW
);

  logic          fpu_enable;
  logic [AW-1:0] fpu_addr;
  logic [DW-1:0] fpu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          wr_enable;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] query_addr;
  logic          query_hit;
  logic          waw_error;

  modport slave (
    input  fpu_enable, fpu_addr, fpu_data, ld_valid, ld_addr, ld_data, query_addr,
    output ld_ready, wr_enable, wr_addr, wr_data, query_hit, waw_error
  );

  modport master (
    output fpu_enable, fpu_addr, fpu_data, ld_valid, ld_addr, ld_data, query_addr,
    input  ld_ready, wr_enable, wr_addr, wr_data, query_hit, waw_error
  );

endinterface

// File: rtl/wb_fifo.sv
// Load-result FIFO with per-entry valid/address taps so the parent can search pending writes.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          entry_valid [DEPTH],
  output logic [AW-1:0] entry_addr  [DEPTH]
);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: storage is deliberately left out of reset; validity is tracked by count/pointers,
  // so stale contents are never observed and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_addr  = addr_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];
  assign entry_addr = addr_mem;

  // Slot i is live when its distance from the read pointer (mod DEPTH) is below count.
  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    logic [PW-1:0] offset;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PW'(i) - rd_ptr;
      entry_valid[i] = ({{(CW-PW){1'b0}}, offset} < count);
    end
  end

endmodule

// File: rtl/fpu_writeback_arbiter.sv
// Float regfile write-port owner: FPU results win every cycle, buffered loads fill the gaps.
module fpu_writeback_arbiter
  import fpu_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input logic                    clk,
  input logic                    reset,
  fpu_writeback_arbiter_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_sel_t;

  logic          ld_push, ld_pop;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          full, empty;
  logic [CW-1:0] count;
  logic          entry_valid [DEPTH];
  logic [AW-1:0] entry_addr  [DEPTH];
  logic          query_hit_c, waw_hit;
  wb_sel_t       sel, wr_q;
  logic          waw_q;

  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (ld_push),
    .push_addr  (bus.ld_addr),
    .push_data  (bus.ld_data),
    .pop        (ld_pop),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .entry_valid(entry_valid),
    .entry_addr (entry_addr)
  );

  // Acceptance looks only at the registered count, never at a same-cycle pop.
  assign bus.ld_ready = ~full & ~reset;
  assign ld_push      = bus.ld_valid & bus.ld_ready;
  assign ld_pop       = ~bus.fpu_enable & ~empty;

  always_comb begin
    query_hit_c = 1'b0;
    waw_hit     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entry_addr[i] == bus.query_addr) query_hit_c = 1'b1;
      if (entry_valid[i] && entry_addr[i] == bus.fpu_addr)   waw_hit     = 1'b1;
    end
  end

  always_comb begin
    sel.en   = bus.fpu_enable | ~empty;
    sel.addr = bus.fpu_enable ? bus.fpu_addr : head_addr;
    sel.data = bus.fpu_enable ? bus.fpu_data : head_data;
  end

  // Address/data hold their last value on idle cycles; only the strobe drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      waw_q <= 1'b0;
    end else begin
      wr_q.en <= sel.en;
      if (sel.en) begin
        wr_q.addr <= sel.addr;
        wr_q.data <= sel.data;
      end
      if (bus.fpu_enable && waw_hit) waw_q <= 1'b1;
    end
  end

  assign bus.wr_enable = wr_q.en;
  assign bus.wr_addr   = wr_q.addr;
  assign bus.wr_data   = wr_q.data;
  assign bus.query_hit = query_hit_c;
  assign bus.waw_error = waw_q;

  a_full_count: assert property (@(posedge clk) disable iff (reset)
    (full == (count == CW'(DEPTH))) && (count <= CW'(DEPTH)));

endmodule

// File: tb/tb_fpu_writeback_arbiter.sv
// Scoreboard bench for fpu_writeback_arbiter: directed scenarios then randomized traffic.
module tb_fpu_writeback_arbiter;
  import fpu_writeback_arbiter_pkg::*;

  localparam int DEPTH = WB_DEPTH;
  localparam int AW    = WB_AW;
  localparam int DW    = WB_DW;

  logic clk = 1'b0;
  logic reset;

  fpu_writeback_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  fpu_writeback_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending loads as a queue, expected writes as a scoreboard queue.
  wb_t           ld_q  [$];
  wb_t           exp_q [$];
  bit            m_waw, m_wr_en, ld_acc;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_data;
  wb_t           m_w;
  bit            m_room;

  always @(posedge clk) begin
    ld_acc = 1'b0;
    if (reset) begin
      ld_q.delete();
      exp_q.delete();
      m_waw       = 1'b0;
      m_wr_en     = 1'b0;
      m_last_addr = '0;
      m_last_data = '0;
    end else begin
      m_room  = ld_q.size() < DEPTH;
      m_wr_en = 1'b0;
      if (bus.fpu_enable) begin
        foreach (ld_q[i]) if (ld_q[i].addr == bus.fpu_addr) m_waw = 1'b1;
        m_w     = '{en: 1'b1, addr: bus.fpu_addr, data: bus.fpu_data};
        m_wr_en = 1'b1;
      end else if (ld_q.size() > 0) begin
        m_w     = ld_q.pop_front();
        m_wr_en = 1'b1;
      end
      if (m_wr_en) begin
        exp_q.push_back(m_w);
        m_last_addr = m_w.addr;
        m_last_data = m_w.data;
      end
      if (bus.ld_valid && m_room) begin
        ld_q.push_back('{en: 1'b1, addr: bus.ld_addr, data: bus.ld_data});
        ld_acc = 1'b1;
      end
    end
  end

  // Monitor: compares outputs against the model on the falling edge.
  wb_t mon_w;
  bit  mon_hit;
  always @(negedge clk) begin
    mon_hit = 1'b0;
    foreach (ld_q[i]) if (ld_q[i].addr == bus.query_addr) mon_hit = 1'b1;
    check("ld_ready",  bus.ld_ready,  (!reset && ld_q.size() < DEPTH));
    check("query_hit", bus.query_hit, mon_hit);
    check("waw_error", bus.waw_error, m_waw);
    check("wr_enable", bus.wr_enable, m_wr_en);
    if (bus.wr_enable) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 1, 0);
      end else begin
        mon_w = exp_q.pop_front();
        check("wr_addr", bus.wr_addr, mon_w.addr);
        check("wr_data", bus.wr_data, mon_w.data);
      end
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      check("wr_addr_hold", bus.wr_addr, m_last_addr);
      check("wr_data_hold", bus.wr_data, m_last_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fpu_enable = 1'b0;
    bus.fpu_addr   = '0;
    bus.fpu_data   = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
    bus.query_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lid;
    idle_inputs();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // 1: idle after reset
    step();
    step();
    check("t1_wr_enable", bus.wr_enable, 0);
    check("t1_ld_ready",  bus.ld_ready,  1);
    check("t1_query_hit", bus.query_hit, 0);
    check("t1_waw_error", bus.waw_error, 0);

    // 2: single load, 2-cycle latency, query visible for one cycle
    bus.query_addr = 5'd3;
    bus.ld_valid   = 1'b1;
    bus.ld_addr    = 5'd3;
    bus.ld_data    = 32'h3F80_0000;
    step();
    bus.ld_valid = 1'b0;
    check("t2_c1_query_hit", bus.query_hit, 1);
    check("t2_c1_wr_enable", bus.wr_enable, 0);
    step();
    check("t2_c2_wr_enable", bus.wr_enable, 1);
    check("t2_c2_wr_addr",   bus.wr_addr,   3);
    check("t2_c2_wr_data",   bus.wr_data,   32'h3F80_0000);
    check("t2_c2_query_hit", bus.query_hit, 0);
    step();

    // 3/4: FPU burst starves loads, FIFO fills, push refused during first pop
    lid = 1;
    for (int c = 0; c < 40 && (c < 6 || lid <= 5); c++) begin
      bus.fpu_enable = (c < 6);
      bus.fpu_addr   = AW'(8 + c);
      bus.fpu_data   = $urandom;
      bus.ld_valid   = (lid <= 5);
      bus.ld_addr    = AW'(lid);
      bus.ld_data    = 32'h1000_0000 + 32'(lid);
      step();
      if (ld_acc) lid++;
      if (c == 3) check("t3_full_ready",      bus.ld_ready, 0);
      if (c == 5) check("t4_pop_push_ready",  bus.ld_ready, 0);
      if (c == 6) check("t4_after_pop_ready", bus.ld_ready, 1);
    end
    idle_inputs();
    repeat (8) step();
    check("t3_all_loads_drained", ld_q.size(), 0);

    // 5: WAW against a pending load is sticky until reset
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 5'd7;
    bus.ld_data  = 32'hDEAD_0007;
    step();
    bus.ld_valid   = 1'b0;
    bus.fpu_enable = 1'b1;
    bus.fpu_addr   = 5'd7;
    bus.fpu_data   = 32'hF00D_0007;
    step();
    bus.fpu_enable = 1'b0;
    check("t5_waw_set", bus.waw_error, 1);
    check("t5_fpu_first_addr", bus.wr_addr, 7);
    check("t5_fpu_first_data", bus.wr_data, 32'hF00D_0007);
    step();
    check("t5_load_second_data", bus.wr_data, 32'hDEAD_0007);
    repeat (3) step();
    check("t5_waw_sticky", bus.waw_error, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_waw_cleared", bus.waw_error, 0);

    // 6: reset mid-drain discards queued loads
    for (int c = 0; c < 4; c++) begin
      bus.fpu_enable = 1'b1;
      bus.fpu_addr   = AW'(20 + c);
      bus.ld_valid   = 1'b1;
      bus.ld_addr    = AW'(16 + c);
      bus.ld_data    = $urandom;
      step();
    end
    idle_inputs();
    step();
    reset = 1'b1;
    step();
    check("t6_reset_wr_enable", bus.wr_enable, 0);
    check("t6_reset_ld_ready",  bus.ld_ready,  0);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("t6_no_write_after_reset", bus.wr_enable, 0);
    end

    // Randomized traffic with occasional resets
    for (int c = 0; c < 800; c++) begin
      reset          = ($urandom_range(0, 99) < 2);
      bus.fpu_enable = $urandom_range(0, 1);
      bus.fpu_addr   = AW'($urandom_range(0, 7));
      bus.fpu_data   = $urandom;
      bus.ld_valid   = ($urandom_range(0, 2) != 0);
      bus.ld_addr    = AW'($urandom_range(0, 7));
      bus.ld_data    = $urandom;
      bus.query_addr = AW'($urandom_range(0, 7));
      step();
    end
    reset = 1'b0;
    idle_inputs();
    for (int c = 0; c < 20 && ld_q.size() > 0; c++) step();
    step();
    check("final_model_empty", ld_q.size(), 0);
    check("final_wr_idle", bus.wr_enable, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
